cdc_handshake_tx: RTL and testbench

Source-domain transmitter for the two-phase (toggle) request/acknowledge clock-domain-crossing protocol. Accepts one word per valid/ready handshake and registers it onto a held data bus. It then toggles a request line and blocks further transfers until the destination's acknowledge toggle returns through a local synchronizer. Sits at the sending end of every multi-bit crossing in the oxbridge fabric, opposite the destination-side receiver.

---
 rtl/oxbridge_cdc_pkg.sv | 21 ++
 rtl/cdc_handshake_tx_chk.sv | 28 ++
 rtl/synchronizer_reg.sv | 23 ++
 rtl/cdc_handshake_tx.sv | 146 ++++++++++++++
 tb/tb_cdc_handshake_tx.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/oxbridge_cdc_pkg.sv
// Shared definitions for the oxbridge toggle-handshake crossing (transmitter and receiver).
package oxbridge_cdc_pkg;

    localparam logic [1:0] ST_ALIGN = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam int SYNC_STAGES_MIN = 2;

    typedef enum logic [1:0] {
        ALIGN = ST_ALIGN,
        IDLE  = ST_IDLE,
        WAIT  = ST_WAIT
    } hs_state_e;

    // Case equality so an unknown synchronizer output reads as "no match".
    function automatic logic toggle_match(input logic ack, input logic req);
        return (ack === req);
    endfunction

endpackage

// File: rtl/cdc_handshake_tx_chk.sv
// Simulation-only protocol checker: flags an ack toggle that arrives while the transmitter is idle.
module cdc_handshake_tx_chk
    import oxbridge_cdc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic       ack_s,
    output logic       violation
);

    logic ack_q;

    // Previous synchronized ack, used to detect a transition.
    always_ff @(posedge clk) begin
        ack_q <= ack_s;
    end

    // Sticky violation flag raised by the assertion's fail action.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            violation <= 1'b0;
        end else begin
            assert (!((state == ST_IDLE) && (ack_s != ack_q))) else violation <= 1'b1;
        end
    end

endmodule

// File: rtl/synchronizer_reg.sv
// Plain multi-flop synchronizer; deliberately unreset so it never holds a reset-induced value.
module synchronizer_reg #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [STAGES];

    // Shift chain: stage 0 samples the asynchronous input.
    always_ff @(posedge clk) begin
        stage_r[0] <= d;
        for (int i = 1; i < STAGES; i++) begin
            stage_r[i] <= stage_r[i-1];
        end
    end

    assign q = stage_r[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of the two-phase req/ack crossing: captures one word, toggles req,
// and blocks further words until the synchronized ack toggle comes back.
module cdc_handshake_tx
    import oxbridge_cdc_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             xfer_req,
    output logic [WIDTH-1:0] xfer_data,
    input  logic             xfer_ack,
    output logic             xfer_done,
    output logic             busy,
    output logic             timeout_err,
    input  logic             err_clr
);

    localparam int STAGES = (SYNC_STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : SYNC_STAGES;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    hs_state_e        state_r;
    hs_state_e        state_next_s;
    logic             ack_s;
    logic             match_s;
    logic             accept_s;
    logic             done_s;
    logic             err_set_s;
    logic             req_r;
    logic [WIDTH-1:0] data_r;
    logic             ready_r;
    logic             busy_r;
    logic             err_r;
    logic [CNT_W-1:0] cnt_r;

    synchronizer_reg #(
        .WIDTH  (1),
        .STAGES (STAGES)
    ) u_ack_sync (
        .clk (clk),
        .d   (xfer_ack),
        .q   (ack_s)
    );

    assign match_s = toggle_match(ack_s, req_r);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ALIGN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; accept and done are single-cycle strobes.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        done_s       = 1'b0;
        case (state_r)
            ALIGN: begin
                if (match_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = ALIGN;
                end
            end
            IDLE: begin
                if (in_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = WAIT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (match_s) begin
                    done_s       = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT;
                end
            end
            default: begin
                state_next_s = ALIGN;
            end
        endcase
    end

    // Request toggle, held data word and state-decoded status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_r   <= 1'b0;
            data_r  <= {WIDTH{1'b0}};
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
        end else begin
            if (accept_s) begin
                req_r  <= ~req_r;
                data_r <= in_data;
            end
            ready_r <= (state_next_s == IDLE);
            busy_r  <= (state_next_s != IDLE);
        end
    end

    // WAIT-cycle counter; saturates so a stuck transfer keeps the error asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == WAIT) && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign err_set_s = (TIMEOUT != 0) && (state_r == WAIT) && !match_s && (cnt_r == CNT_MAX);

    // Sticky timeout flag; a fresh set outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (err_set_s) begin
            err_r <= 1'b1;
        end else if (err_clr) begin
            err_r <= 1'b0;
        end
    end

    assign in_ready    = ready_r;
    assign busy        = busy_r;
    assign xfer_req    = req_r;
    assign xfer_data   = data_r;
    assign xfer_done   = done_s;
    assign timeout_err = err_r;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for cdc_handshake_tx with a behavioural destination model.
module tb_cdc_handshake_tx;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             xfer_req;
    logic [WIDTH-1:0] xfer_data;
    logic             xfer_ack;
    logic             xfer_done;
    logic             busy;
    logic             timeout_err;
    logic             err_clr;
    logic             violation;

    logic             rx_zero;
    logic             ack_drv;
    int               done_cnt = 0;
    int               checks   = 0;
    int               errors   = 0;

    logic [WIDTH-1:0] words [8] = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000,
                                    32'hA5A5_5A5A, 32'h1234_5678, 32'hCAFE_F00D, 32'h0F0F_F0F0};

    assign xfer_ack = rx_zero ? xfer_req : ack_drv;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (xfer_done) done_cnt <= done_cnt + 1;
    end

    cdc_handshake_tx #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (2),
        .TIMEOUT     (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .xfer_req    (xfer_req),
        .xfer_data   (xfer_data),
        .xfer_ack    (xfer_ack),
        .xfer_done   (xfer_done),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    cdc_handshake_tx_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .state     (dut.state_r),
        .ack_s     (dut.ack_s),
        .violation (violation)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int     base;
        int     idx;
        int     guard;
        longint t_prev;
        longint t_now;
        logic   exp_req;

        rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; err_clr = 1'b0;
        rx_zero = 1'b0; ack_drv = 1'b1;

        // Reset values, then release with the destination ack coming out at 0.
        repeat (3) tick();
        check_eq("rst_ready", in_ready, 1'b0);
        check_eq("rst_busy", busy, 1'b1);
        check_eq("rst_req", xfer_req, 1'b0);
        check_eq("rst_data", xfer_data, 32'h0);
        check_eq("rst_done", xfer_done, 1'b0);
        check_eq("rst_err", timeout_err, 1'b0);
        rst = 1'b0; ack_drv = 1'b0;
        tick(); check_eq("align_ready_1", in_ready, 1'b0);
        tick(); check_eq("align_ready_2", in_ready, 1'b0);
        tick(); check_eq("align_ready_3", in_ready, 1'b1);
        check_eq("align_busy", busy, 1'b0);

        // Single word, destination acks three cycles after seeing req.
        base = done_cnt;
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        tick();
        in_valid = 1'b0; in_data = 32'h1234_5678;
        check_eq("one_req", xfer_req, 1'b1);
        check_eq("one_data", xfer_data, 32'hDEAD_BEEF);
        check_eq("one_ready", in_ready, 1'b0);
        check_eq("one_busy", busy, 1'b1);
        repeat (3) begin
            tick();
            check_eq("one_hold", xfer_data, 32'hDEAD_BEEF);
        end
        ack_drv = 1'b1;
        tick(); check_eq("one_done_early", xfer_done, 1'b0);
        tick(); check_eq("one_done", xfer_done, 1'b1);
        tick();
        check_eq("one_done_after", xfer_done, 1'b0);
        check_eq("one_ready_back", in_ready, 1'b1);
        check_eq("one_busy_low", busy, 1'b0);
        check_eq("one_hold_idle", xfer_data, 32'hDEAD_BEEF);
        check_eq("one_done_cnt", done_cnt - base, 1);

        // Back-to-back words with a zero-latency destination.
        rx_zero = 1'b1;
        base = done_cnt; exp_req = 1'b1; idx = 0; guard = 0; t_prev = 0;
        in_valid = 1'b1; in_data = words[0];
        while (idx < 8 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (in_ready) begin
                t_now = $time;
                if (idx > 0) check_eq("b2b_spacing", (t_now - t_prev) / 10, 4);
                t_prev = t_now;
                tick();
                exp_req = ~exp_req;
                check_eq("b2b_req", xfer_req, exp_req);
                check_eq("b2b_data", xfer_data, words[idx]);
                idx++;
                if (idx < 8) in_data = words[idx];
                else in_valid = 1'b0;
            end
        end
        check_eq("b2b_count", idx, 8);
        repeat (4) tick();
        check_eq("b2b_done_cnt", done_cnt - base, 8);
        ack_drv = 1'b1;
        rx_zero = 1'b0;

        // Silent destination: timeout flag after the counter reaches 15.
        in_valid = 1'b1; in_data = 32'hA5A5_0001;
        tick();
        in_valid = 1'b0;
        check_eq("to_req", xfer_req, 1'b0);
        repeat (15) tick();
        check_eq("to_err_before", timeout_err, 1'b0);
        tick();
        check_eq("to_err_set", timeout_err, 1'b1);
        check_eq("to_still_wait", busy, 1'b1);
        check_eq("to_ready_low", in_ready, 1'b0);
        ack_drv = 1'b0;
        tick(); tick();
        check_eq("to_late_done", xfer_done, 1'b1);
        tick();
        check_eq("to_late_ready", in_ready, 1'b1);
        check_eq("to_err_sticky", timeout_err, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("to_err_clr", timeout_err, 1'b0);

        // Clear coincident with a new timeout set: the set wins.
        in_valid = 1'b1; in_data = 32'hA5A5_0002;
        tick();
        in_valid = 1'b0;
        repeat (15) tick();
        check_eq("to2_err_before", timeout_err, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_eq("to2_set_wins", timeout_err, 1'b1);
        ack_drv = 1'b1;
        repeat (3) tick();
        check_eq("to2_ready", in_ready, 1'b1);

        // Reset mid-WAIT with ack_s=1; destination reset four cycles later.
        in_valid = 1'b1; in_data = 32'h5555_AAAA;
        tick();
        in_valid = 1'b0;
        check_eq("mid_req", xfer_req, 1'b0);
        tick(); tick();
        rst = 1'b1;
        #1;
        check_eq("mid_rst_req", xfer_req, 1'b0);
        check_eq("mid_rst_ready", in_ready, 1'b0);
        check_eq("mid_rst_data", xfer_data, 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        check_eq("mid_align_ready", in_ready, 1'b0);
        check_eq("mid_align_err", timeout_err, 1'b0);
        ack_drv = 1'b0;
        tick(); check_eq("mid_ready_1", in_ready, 1'b0);
        tick(); check_eq("mid_ready_2", in_ready, 1'b0);
        tick(); check_eq("mid_ready_3", in_ready, 1'b1);

        // Spurious ack toggle while idle.
        check_eq("spur_clean", violation, 1'b0);
        base = done_cnt;
        ack_drv = 1'b1;
        repeat (4) tick();
        check_eq("spur_no_done", done_cnt - base, 0);
        check_eq("spur_ready", in_ready, 1'b1);
        check_eq("spur_busy", busy, 1'b0);
        check_eq("spur_flag", violation, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
